// File: rtl/sigma_delta_pkg.sv
// Shared constants and types for the sigma-delta ADC sample sequencer.
package sigma_delta_pkg;

    localparam int SEQ_NUM_CH = 4;
    localparam int DISC_CNT_W = 4;
    localparam int OVR_CNT_W  = 8;

    typedef logic [$clog2(SEQ_NUM_CH)-1:0] ch_idx_t;

    // Saturating increment for the per-channel lost-sample counters.
    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sigma_delta_rr_arbiter.sv
// Combinational round-robin search: first requester above last_grant, wrapping.
module sigma_delta_rr_arbiter
    import sigma_delta_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int k = NUM_CH; k >= 1; k--) begin
            int idx;
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) begin
                grant       = CH_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc_sequencer.sv
// Multi-channel ADC sample capture, start-up discard and round-robin streaming.
// Optional SIGMA_DELTA_SEQ_OVERRUN_CNT_EN adds per-channel lost-sample counters.
module sigma_delta_adc_sequencer
    import sigma_delta_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ADC_BITLEN      = 24,
    parameter int DISCARD_SAMPLES = 2,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH*ADC_BITLEN-1:0] adc_output,
    input  logic [NUM_CH-1:0]            adc_valid,
    output logic [ADC_BITLEN-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         clear_overrun,
    output logic [NUM_CH-1:0]            overrun
`ifdef SIGMA_DELTA_SEQ_OVERRUN_CNT_EN
    ,
    output logic [NUM_CH*OVR_CNT_W-1:0]  overrun_cnt
`endif
);

    logic [ADC_BITLEN-1:0] sample   [NUM_CH];
    logic [ADC_BITLEN-1:0] hold     [NUM_CH];
    logic [DISC_CNT_W-1:0] disc_cnt [NUM_CH];

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] take_vec;
    logic [NUM_CH-1:0] overrun_set;
    logic [NUM_CH-1:0] req;

    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] grant;
    logic            grant_valid;
    logic            out_free;
    logic            take;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign sample[gi]      = adc_output[gi*ADC_BITLEN +: ADC_BITLEN];
            assign capture[gi]     = ch_en[gi] & adc_valid[gi] & (disc_cnt[gi] == '0);
            assign take_vec[gi]    = take & (grant == CH_W'(gi));
            assign overrun_set[gi] = capture[gi] & full[gi] & ~take_vec[gi];
        end
    endgenerate

    // A fresh capture also requests, so an idle output forwards it the next cycle.
    assign req      = full | capture;
    assign out_free = ~out_valid | out_ready;
    assign take     = out_free & grant_valid;

    sigma_delta_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                disc_cnt[i] <= DISC_CNT_W'(DISCARD_SAMPLES);
                hold[i]     <= '0;
            end
            full    <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i]) begin
                    disc_cnt[i] <= DISC_CNT_W'(DISCARD_SAMPLES);
                    full[i]     <= 1'b0;
                end else begin
                    if (adc_valid[i] && disc_cnt[i] != '0)
                        disc_cnt[i] <= disc_cnt[i] - 1'b1;
                    if (capture[i]) begin
                        hold[i] <= sample[i];
                        // Stays empty only when the new sample bypasses straight to the output.
                        full[i] <= full[i] | ~take_vec[i];
                    end else if (take_vec[i]) begin
                        full[i] <= 1'b0;
                    end
                end
                overrun[i] <= overrun_set[i] | (overrun[i] & ~clear_overrun);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (out_free) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data   <= full[grant] ? hold[grant] : sample[grant];
                out_ch     <= grant;
                last_grant <= grant;
            end
        end
    end

`ifdef SIGMA_DELTA_SEQ_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ovr_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (overrun_set[i])
                    ovr_cnt[i] <= clear_overrun ? OVR_CNT_W'(1) : sat_inc(ovr_cnt[i]);
                else if (clear_overrun)
                    ovr_cnt[i] <= '0;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            assign overrun_cnt[gi*OVR_CNT_W +: OVR_CNT_W] = ovr_cnt[gi];
        end
    endgenerate
`else
    // Only the sticky overrun flags are kept in this build.
`endif

endmodule

// File: tb/tb_sigma_delta_adc_sequencer.sv
// Self-checking bench for sigma_delta_adc_sequencer (NUM_CH=4, 24-bit, 2 discards).
module tb_sigma_delta_adc_sequencer;
    import sigma_delta_pkg::*;

    localparam int NUM_CH = 4;
    localparam int BITS   = 24;

    logic               clk;
    logic               rst;
    logic [NUM_CH-1:0]  ch_en;
    logic [NUM_CH*BITS-1:0] adc_output;
    logic [NUM_CH-1:0]  adc_valid;
    logic [BITS-1:0]    out_data;
    ch_idx_t            out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               clear_overrun;
    logic [NUM_CH-1:0]  overrun;
`ifdef SIGMA_DELTA_SEQ_OVERRUN_CNT_EN
    logic [NUM_CH*8-1:0] overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [BITS+1:0] exp_q[$];

    sigma_delta_adc_sequencer #(
        .NUM_CH          (NUM_CH),
        .ADC_BITLEN      (BITS),
        .DISCARD_SAMPLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_en         (ch_en),
        .adc_output    (adc_output),
        .adc_valid     (adc_valid),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .overrun       (overrun)
`ifdef SIGMA_DELTA_SEQ_OVERRUN_CNT_EN
        ,
        .overrun_cnt   (overrun_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // Scoreboard: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got ch=%0d data=%h, queue empty", out_ch, out_data);
            end else begin
                logic [BITS+1:0] e;
                e = exp_q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat got ch=%0d data=%h expected ch=%0d data=%h",
                             out_ch, out_data, e[BITS+1:BITS], e[BITS-1:0]);
                end
            end
        end
    end

    // Driver tasks (called at posedge+1, return at posedge+1)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] mask, input logic [BITS-1:0] v0, v1, v2, v3);
        adc_valid  = mask;
        adc_output = {v3, v2, v1, v0};
        @(posedge clk);
        #1;
        adc_valid = '0;
    endtask

    task automatic strobe1(input int ch, input logic [BITS-1:0] v);
        logic [NUM_CH-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        strobe(m, v, v, v, v);
    endtask

    task automatic push(input int ch, input logic [BITS-1:0] v);
        exp_q.push_back({ch_idx_t'(ch), v});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d beats pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; ch_en = '1; adc_output = '0; adc_valid = '0;
        out_ready = 1'b1; clear_overrun = 1'b0;
        idle(3);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || overrun !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h ch=%0d ovr=%b required 0/0/0/0",
                     out_valid, out_data, out_ch, overrun);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);
    endtask

    task automatic test_discard();
        strobe1(1, 24'h000010);
        idle(1);
        strobe1(1, 24'h000020);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_drop got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        push(1, 24'h000030);
        strobe1(1, 24'h000030);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 24'h000030) begin
            errors++;
            $display("FAIL discard_latency got valid=%b ch=%0d data=%h required 1/1/000030",
                     out_valid, out_ch, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_single_beat got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        // Burn the start-up discards of the remaining channels together.
        strobe(4'b1101, 24'h1, 24'h1, 24'h1, 24'h1);
        strobe(4'b1101, 24'h2, 24'h2, 24'h2, 24'h2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_multi got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        push(3, 24'h00003C);
        strobe1(3, 24'h00003C);
        wait_drain("discard");
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 2; r++) begin
            logic [BITS-1:0] base;
            base = (r == 0) ? 24'hA0 : 24'hB0;
            for (int k = 0; k < NUM_CH; k++) push(k, base + BITS'(k));
            strobe(4'b1111, base, base + 24'd1, base + 24'd2, base + 24'd3);
            for (int k = 0; k < NUM_CH; k++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_ch !== ch_idx_t'(k)) begin
                    errors++;
                    $display("FAIL rr_order round %0d slot %0d got valid=%b ch=%0d required 1/%0d",
                             r, k, out_valid, out_ch, k);
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle got valid=%b required 0", out_valid);
            end
            @(posedge clk); #1;
        end
        wait_drain("rr");
    endtask

    task automatic test_stall_overrun();
        out_ready = 1'b0;
        push(1, 24'h000055);
        strobe1(1, 24'h000055);
        strobe1(2, 24'h000111);
        strobe1(2, 24'h000222);
        idle(2);
        @(negedge clk);
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL stall_overrun got %b required 0100", overrun);
        end
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 24'h000055) begin
            errors++;
            $display("FAIL stall_hold got valid=%b ch=%0d data=%h required 1/1/000055",
                     out_valid, out_ch, out_data);
        end
        @(posedge clk); #1;
        push(2, 24'h000222);
        out_ready = 1'b1;
        wait_drain("stall");
        clear_overrun = 1'b1;
        idle(1);
        clear_overrun = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 4'b0000) begin
            errors++;
            $display("FAIL overrun_clear got %b required 0000", overrun);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_capture_during_transfer();
        out_ready = 1'b0;
        push(1, 24'h000061);
        strobe1(1, 24'h000061);
        push(0, 24'h000070);
        strobe1(0, 24'h000070);
        push(0, 24'h000071);
        out_ready = 1'b1;
        strobe1(0, 24'h000071);
        wait_drain("xfer");
        @(negedge clk);
        checks++;
        if (overrun !== 4'b0000) begin
            errors++;
            $display("FAIL xfer_no_overrun got %b required 0000", overrun);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_disable();
        out_ready = 1'b0;
        push(1, 24'h000081);
        strobe1(1, 24'h000081);
        strobe1(3, 24'h000093);
        ch_en = 4'b0111;
        idle(1);
        ch_en = 4'b1111;
        out_ready = 1'b1;
        wait_drain("disable");
        idle(2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL disable_dropped got valid=%b ch=%0d required valid 0", out_valid, out_ch);
        end
        @(posedge clk); #1;
        strobe1(3, 24'h000094);
        strobe1(3, 24'h000095);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reenable_discard got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        push(3, 24'h000096);
        strobe1(3, 24'h000096);
        wait_drain("reenable");
    endtask

    task automatic test_reset_and_clear();
        out_ready = 1'b0;
        strobe1(1, 24'h0000C1);
        strobe1(2, 24'h0000C2);
        clear_overrun = 1'b1;
        strobe1(2, 24'h0000C3);
        clear_overrun = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL clear_vs_set got %b required 0100", overrun);
        end
        mon_en = 1'b0;
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || overrun !== '0) begin
            errors++;
            $display("FAIL async_reset got valid=%b data=%h ch=%0d ovr=%b required 0/0/0/0",
                     out_valid, out_data, out_ch, overrun);
        end
        @(posedge clk); #1;
        idle(1);
        rst = 1'b0;
        mon_en = 1'b1;
        out_ready = 1'b1;
        strobe1(0, 24'h0000D0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_reloads_discard got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_discard();
        test_round_robin();
        test_stall_overrun();
        test_capture_during_transfer();
        test_disable();
        test_reset_and_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigma_delta_adc_sequencer.md
# sigma_delta_adc_sequencer

Multi-channel sample scheduler between NUM_CH `sigma_delta_adc` instances and a single downstream consumer.
- Captures each channel's decimated sample on its `adc_valid` pulse and drops the CIC start-up transient after reset or channel enable.
- Holds one sample per channel and round-robin arbitrates the held samples onto one valid/ready stream tagged with the channel number.
- Flags channels whose samples are lost because the consumer stalls.

## Interface
- NUM_CH, 4: number of ADC channels, 2..16
- ADC_BITLEN, 24: sample width, equals the ADC's ADC_BITLEN
- DISCARD_SAMPLES, 2: samples dropped per channel after reset or enable, 0..15; normally CIC_STAGES
- clk  in  1  system clock, also the ADC oversample clock
- rst  in  1  asynchronous reset, active-high
- ch_en  in  NUM_CH  per-channel enable
- adc_output  in  NUM_CH*ADC_BITLEN  flattened channel samples; channel i is bits [i*ADC_BITLEN +: ADC_BITLEN]
- adc_valid  in  NUM_CH  one-cycle sample strobe per channel
- out_data  out  ADC_BITLEN  granted sample
- out_ch  out  $clog2(NUM_CH)  channel number of out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  consumer accepts when high together with out_valid
- clear_overrun  in  1  clears all overrun flags
- overrun  out  NUM_CH  sticky per-channel sample-loss flag

## Operation
- **Per-channel state:** discard counter, hold register, `full` bit, sticky `overrun` bit.
- **Discard:** the counter loads DISCARD_SAMPLES on reset and whenever `ch_en[i]` is low.
  - While the counter is nonzero, each `adc_valid[i]` decrements it and the sample is dropped.
  - When the counter is zero, each `adc_valid[i]` captures the sample.
- **Capture:** writes `adc_output[i]` into hold register i and sets `full[i]`.
- **Overwrite:** a capture when `full[i]` is set and the channel is not being transferred in the same cycle overwrites the old sample (newest kept) and sets `overrun[i]`.
- **Capture during transfer:** a capture in the same cycle that channel i's held sample transfers to the output stage is not an overrun. `full[i]` remains set with the new sample.
- **Disable:** `ch_en[i]` low clears `full[i]` and ignores `adc_valid[i]`. It does not clear `overrun[i]`.
- **Arbitration:** the output register is free when `out_valid` is low, or when `out_valid` and `out_ready` are both high.
  - When the output register is free, the arbiter grants the first channel with `full` set, searching upward (with wrap) starting from last_grant+1.
  - The granted sample and index load into the output register, `out_valid` is set, the granted channel's `full` clears, and last_grant updates.
  - If no channel is full, `out_valid` goes low when the current beat completes.
- **Handshake:** `out_data` and `out_ch` are held stable while `out_valid` is high and `out_ready` is low. `out_valid` is never withdrawn without a transfer.
- **Overrun flags:** `clear_overrun` clears every `overrun` bit. A set event in the same cycle as `clear_overrun` wins; the flag reads 1.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_ch`=0, `overrun`=0, all `full`=0, last_grant=NUM_CH-1 (so channel 0 has first priority), discard counters=DISCARD_SAMPLES.
- **Latency:** `adc_valid[i]` high in cycle N sets `full[i]` at the end of cycle N. With the output free, `out_valid` is high with that sample in cycle N+1.
- **Throughput:** one sample per cycle sustained, full back-to-back.
- **Simultaneous strobes:** when all channels strobe in one cycle, they are emitted in round-robin order over consecutive cycles.
- **Reset during a stalled beat:** asynchronous reset drops `out_valid` immediately. The consumer must treat that beat as lost.

## Configuration
- **Macro `SIGMA_DELTA_SEQ_OVERRUN_CNT_EN`** — when defined, adds one output port:
  - overrun_cnt  out  NUM_CH*8  per-channel count of lost samples.
  - Each counter saturates at 255 and is cleared by `clear_overrun`; a same-cycle increment wins and loads 1.
- **Without the macro:** the port and counters are absent; only the sticky flags exist.

## Structure
- **Shared package `sigma_delta_pkg`** holds:
  - the channel-index typedef sized by `$clog2(NUM_CH)`;
  - the DISCARD_SAMPLES counter-width constant (4 bits);
  - the overrun counter width constant (8).
- **Sub-module `sigma_delta_rr_arbiter`:**
  - Inputs: NUM_CH request vector, last_grant.
  - Outputs: grant index and grant-valid.
  - Purely combinational search; last_grant is registered in the parent.

## Test plan
1. **Start-up discard:** NUM_CH=4, DISCARD_SAMPLES=2, all enabled, `out_ready`=1; strobe channel 1 with 0x000010, 0x000020, 0x000030 → only 0x000030 appears, `out_ch`=1, `out_valid` high exactly one cycle after the third strobe.
2. **Round-robin:** all four channels strobe in one cycle with values 0xA0..0xA3 → outputs in order ch0, ch1, ch2, ch3 on four consecutive cycles. A second simultaneous strobe is emitted starting at ch0 (last_grant was 3).
3. **Stall/overrun:** `out_ready`=0 while channel 2 strobes 0x111 then 0x222 → `out_data` stays on the first granted value, `overrun[2]`=1. Raising `out_ready` then emits 0x222 for channel 2; 0x111 is emitted only if it was already in the output register.
4. **Capture during transfer:** channel 0 strobes in the same cycle its held sample is granted → no overrun, new sample follows on the next beat.
5. **Disable/re-enable:** drop `ch_en[3]` while `full[3]`=1 → sample never emitted. Re-enable → next 2 strobes discarded.
6. **Reset and clear:** async `rst` mid-stall → `out_valid` low immediately, all state at reset values. `clear_overrun` together with a new overrun event → flag reads 1.
